// File: rtl/spi_ram_pkg.sv
// Purpose    : shared opcodes, read-FSM states and default sizes for the SPI RAM stage.
// Latency    : n/a (types and constants only).
// Backpressure: n/a.
package spi_ram_pkg;

    localparam int DEF_MEM_DEPTH = 256;
    localparam int DEF_ADDR_SIZE = 8;
    localparam int DEF_ERR_W     = 8;

    // Opcode carried in din[9:8]
    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_e;

    // Read-side sequencer
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ADDR_HELD = 2'b01,
        FETCH     = 2'b10
    } rd_state_e;

    // Split a 10-bit SPI word into opcode and payload.
    function automatic cmd_e word_cmd(input logic [9:0] word);
        return cmd_e'(word[9:8]);
    endfunction

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// Purpose    : bundles the SPI-slave word input, the read-data return and status flags.
// Latency    : n/a (wires only).
// Backpressure: none; the SPI slave spaces rx_valid words at least 10 clocks apart.
// Signals    : din/rx_valid (command in), dout/tx_valid (read byte out),
//              seq_err/err_cnt (sequence errors), rd_pending (read address held).
interface spi_ram_ctrl_if #(
    parameter int ERR_W = 8
);
    logic [9:0]       din;
    logic             rx_valid;
    logic [7:0]       dout;
    logic             tx_valid;
    logic             seq_err;
    logic [ERR_W-1:0] err_cnt;
    logic             rd_pending;

    // Memory stage side
    modport slave (
        input  din, rx_valid,
        output dout, tx_valid, seq_err, err_cnt, rd_pending
    );

    // SPI slave / test driver side
    modport master (
        output din, rx_valid,
        input  dout, tx_valid, seq_err, err_cnt, rd_pending
    );
endinterface

// File: rtl/spi_ram_array.sv
// Purpose    : single-port MEM_DEPTH x 8 RAM, write-first, registered read port.
// Latency    : rdata reflects addr one clock after it is presented.
// Backpressure: none; one access per clock, no reset on contents.
// Ports      : clk, we, addr, wdata in; rdata out.
module spi_ram_array #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata
);

    logic [7:0] mem [MEM_DEPTH];

    // Write-first: a write also returns the new byte on rdata.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Purpose    : decodes SPI command words into RAM writes/reads, with sequence checking.
// Latency    : tx_valid/dout registered one clock after the RD_DATA sample; the slave
//              picks it up on the following edge. seq_err one clock after the offending word.
// Backpressure: none; relies on rx_valid words being at least 10 clocks apart.
// Ports      : clk, rst_n (async, active-low); bus = spi_ram_ctrl_if.slave.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int ERR_W     = DEF_ERR_W
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_ram_ctrl_if.slave  bus
);

    cmd_e                 cmd;
    logic [7:0]           payload;

    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 wr_addr_vld;
    logic [7:0]           dout_q;
    logic                 tx_valid_q;
    logic                 seq_err_q;
    logic [ERR_W-1:0]     err_cnt_q;

    rd_state_e            state_q;
    rd_state_e            state_d;

    logic                 do_wr_addr;
    logic                 do_wr_data;
    logic                 do_rd_addr;
    logic                 do_rd_data;
    logic                 wr_ok;
    logic                 wr_bad;
    logic                 rd_ok;
    logic                 rd_bad;
    logic                 load_dout;

    logic [ADDR_SIZE-1:0] ram_addr;
    logic [7:0]           ram_rdata;

    assign cmd     = word_cmd(bus.din);
    assign payload = bus.din[7:0];

    assign do_wr_addr = bus.rx_valid && (cmd == WR_ADDR);
    assign do_wr_data = bus.rx_valid && (cmd == WR_DATA);
    assign do_rd_addr = bus.rx_valid && (cmd == RD_ADDR);
    assign do_rd_data = bus.rx_valid && (cmd == RD_DATA);

    assign wr_ok  = do_wr_data &&  wr_addr_vld;
    assign wr_bad = do_wr_data && !wr_addr_vld;

    // ------------------------------------------------------------------
    // Read sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_ok     = 1'b0;
        rd_bad    = do_rd_data;
        load_dout = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (do_rd_addr) begin
                    state_d = ADDR_HELD;
                end
            end
            ADDR_HELD: begin
                // A repeated RD_ADDR just retargets the held address.
                if (do_rd_data) begin
                    rd_ok   = 1'b1;
                    rd_bad  = 1'b0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // RAM captured mem[rd_addr] on the RD_DATA edge; hand it out now.
                load_dout = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RAM: the port follows rd_addr except on an accepted write, so the
    // RD_DATA edge itself latches the read byte into ram_rdata.
    // ------------------------------------------------------------------
    assign ram_addr = wr_ok ? wr_addr : rd_addr;

    spi_ram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_array (
        .clk   (clk),
        .we    (wr_ok),
        .addr  (ram_addr),
        .wdata (payload),
        .rdata (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Address, output and error registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr     <= '0;
            wr_addr_vld <= 1'b0;
            rd_addr     <= '0;
            dout_q      <= '0;
            tx_valid_q  <= 1'b0;
            seq_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            if (do_wr_addr) begin
                wr_addr     <= payload[ADDR_SIZE-1:0];
                wr_addr_vld <= 1'b1;
            end else if (wr_ok) begin
                // Natural wrap: MEM_DEPTH is exactly 2**ADDR_SIZE.
                wr_addr <= wr_addr + 1'b1;
            end

            if (do_rd_addr) begin
                rd_addr <= payload[ADDR_SIZE-1:0];
            end

            tx_valid_q <= load_dout;
            if (load_dout) begin
                dout_q <= ram_rdata;
            end

            seq_err_q <= wr_bad || rd_bad;
            if ((wr_bad || rd_bad) && (err_cnt_q != {ERR_W{1'b1}})) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.seq_err    = seq_err_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.rd_pending = (state_q == ADDR_HELD);

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Purpose    : self-checking bench for spi_ram_ctrl (8-bit and 4-bit address instances).
// Latency    : checks tx_valid registered one clock after the RD_DATA sample.
// Backpressure: n/a; commands spaced 11 clocks apart.
module tb_spi_ram_ctrl;
    import spi_ram_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    spi_ram_ctrl_if #(.ERR_W(8)) if0 ();
    spi_ram_ctrl_if #(.ERR_W(8)) if1 ();

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .ERR_W(8)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    spi_ram_ctrl #(.MEM_DEPTH(16), .ADDR_SIZE(4), .ERR_W(8)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    // Drive and observe both instances through index-able arrays.
    logic [9:0] drv_din [2];
    logic       drv_vld [2];
    logic [7:0] o_dout  [2];
    logic       o_tx    [2];
    logic       o_seq   [2];
    logic [7:0] o_err   [2];
    logic       o_pend  [2];

    assign if0.din      = drv_din[0];
    assign if0.rx_valid = drv_vld[0];
    assign if1.din      = drv_din[1];
    assign if1.rx_valid = drv_vld[1];
    assign o_dout[0] = if0.dout;      assign o_dout[1] = if1.dout;
    assign o_tx[0]   = if0.tx_valid;  assign o_tx[1]   = if1.tx_valid;
    assign o_seq[0]  = if0.seq_err;   assign o_seq[1]  = if1.seq_err;
    assign o_err[0]  = if0.err_cnt;   assign o_err[1]  = if1.err_cnt;
    assign o_pend[0] = if0.rd_pending; assign o_pend[1] = if1.rd_pending;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model
    logic [7:0] mmem   [2][256];
    logic [7:0] m_wa   [2];
    logic       m_wv   [2];
    logic [7:0] m_ra   [2];
    logic       m_pend [2];
    int         m_err  [2];
    logic [7:0] m_dout [2];

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    // Scoreboard: every tx_valid pops the byte queued when its RD_DATA was sent.
    always @(negedge clk) begin
        if (o_tx[0]) begin
            if (q0.size() == 0) chk("tx0_unexpected", 1, 0);
            else                chk("dout0", o_dout[0], q0.pop_front());
        end
        if (o_tx[1]) begin
            if (q1.size() == 0) chk("tx1_unexpected", 1, 0);
            else                chk("dout1", o_dout[1], q1.pop_front());
        end
    end

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_wa[s] = 8'h00; m_wv[s] = 1'b0; m_ra[s] = 8'h00;
            m_pend[s] = 1'b0; m_err[s] = 0; m_dout[s] = 8'h00;
        end
    endtask

    task automatic send(input int sel, input cmd_e cmd, input logic [7:0] p);
        logic [7:0] amask;
        logic       err;
        logic       tx;
        amask = (sel == 1) ? 8'h0F : 8'hFF;
        err = 1'b0;
        tx  = 1'b0;
        case (cmd)
            WR_ADDR: begin m_wa[sel] = p & amask; m_wv[sel] = 1'b1; end
            WR_DATA: begin
                if (m_wv[sel]) begin
                    mmem[sel][m_wa[sel]] = p;
                    m_wa[sel] = (m_wa[sel] + 8'd1) & amask;
                end else err = 1'b1;
            end
            RD_ADDR: begin m_ra[sel] = p & amask; m_pend[sel] = 1'b1; end
            RD_DATA: begin
                if (m_pend[sel]) begin
                    tx = 1'b1;
                    m_pend[sel] = 1'b0;
                    m_dout[sel] = mmem[sel][m_ra[sel]];
                    if (sel == 1) q1.push_back(m_dout[sel]);
                    else          q0.push_back(m_dout[sel]);
                end else err = 1'b1;
            end
            default: ;
        endcase
        if (err && m_err[sel] < 255) m_err[sel]++;

        @(negedge clk);
        drv_din[sel] = {cmd, p};
        drv_vld[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drv_vld[sel] = 1'b0;
        chk("seq_err", o_seq[sel], err);
        chk("err_cnt", o_err[sel], m_err[sel]);
        chk("rd_pending", o_pend[sel], m_pend[sel]);
        chk("tx_early", o_tx[sel], 0);
        @(negedge clk);
        chk("tx_valid", o_tx[sel], tx);
        chk("seq_err_width", o_seq[sel], 0);
        if (!tx) chk("dout_hold", o_dout[sel], m_dout[sel]);
        @(negedge clk);
        chk("tx_width", o_tx[sel], 0);
        chk("dout_keep", o_dout[sel], m_dout[sel]);
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        drv_din[0] = '0; drv_din[1] = '0;
        drv_vld[0] = 1'b0; drv_vld[1] = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_dout", o_dout[0], 0);
        chk("rst_tx", o_tx[0], 0);
        chk("rst_seq", o_seq[0], 0);
        chk("rst_err", o_err[0], 0);
        chk("rst_pend", o_pend[0], 0);

        // Seed address 0 so a stray post-reset write would be visible.
        send(0, WR_ADDR, 8'h00);
        send(0, WR_DATA, 8'h99);
        do_reset();

        // Illegal sequences straight out of reset.
        send(0, RD_DATA, 8'h00);
        send(0, WR_DATA, 8'h77);
        send(0, RD_ADDR, 8'h00);
        send(0, RD_DATA, 8'h00);

        // Basic write burst and reads.
        send(0, WR_ADDR, 8'h10);
        send(0, WR_DATA, 8'hA5);
        send(0, WR_DATA, 8'h3C);
        send(0, RD_ADDR, 8'h10);
        send(0, RD_DATA, 8'h00);
        send(0, RD_ADDR, 8'h11);
        send(0, RD_DATA, 8'hFF);

        // Write-address wrap.
        send(0, WR_ADDR, 8'hFF);
        send(0, WR_DATA, 8'h11);
        send(0, WR_DATA, 8'h22);
        send(0, RD_ADDR, 8'hFF);
        send(0, RD_DATA, 8'h00);
        send(0, RD_ADDR, 8'h00);
        send(0, RD_DATA, 8'h00);

        // Overwritten read address, then a dangling RD_DATA.
        send(0, WR_ADDR, 8'h20);
        send(0, WR_DATA, 8'h5E);
        send(0, WR_ADDR, 8'h30);
        send(0, WR_DATA, 8'hC7);
        send(0, RD_ADDR, 8'h20);
        send(0, RD_ADDR, 8'h30);
        send(0, RD_DATA, 8'h00);
        send(0, RD_DATA, 8'h00);

        // Address truncation on the 4-bit instance.
        send(1, WR_ADDR, 8'hF3);
        send(1, WR_DATA, 8'h5A);
        send(1, WR_DATA, 8'h6B);
        send(1, RD_ADDR, 8'h03);
        send(1, RD_DATA, 8'h00);
        send(1, RD_ADDR, 8'hE4);
        send(1, RD_DATA, 8'h00);

        // Reset while a read is in flight.
        send(0, RD_ADDR, 8'h10);
        @(negedge clk);
        drv_din[0] = {RD_DATA, 8'h00};
        drv_vld[0] = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        drv_vld[0] = 1'b0;
        #1;
        chk("arst_tx", o_tx[0], 0);
        chk("arst_pend", o_pend[0], 0);
        chk("arst_dout", o_dout[0], 0);
        chk("arst_err", o_err[0], 0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_tx", o_tx[0], 0);
        end

        // Error counter saturation.
        for (int i = 0; i < 259; i++) begin
            send(0, RD_DATA, 8'h00);
        end
        chk("err_sat", o_err[0], 8'hFF);

        repeat (4) @(negedge clk);
        chk("q0_drain", q0.size(), 0);
        chk("q1_drain", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
